// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I core front end.
//   XLEN             datapath width
//   NOP_INSTR        canonical bubble (addi x0, x0, 0)
//   RESET_PC_DEFAULT default reset byte address
//   fetch_state_e    instruction-fetch FSM states
package rv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    TRAP = 2'b10
  } fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction-memory address/data and the IF/ID register
// contents handed to the decoder.
//   master (fetch stage): drives im_addr and ifid_*, reads im_instr
//   slave  (IM/decoder) : drives im_instr, reads im_addr and ifid_*
interface if_stage_if;
  logic [15:0] im_addr;
  logic [31:0] im_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;

  modport master (
    output im_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr,
    input  im_instr
  );

  modport slave (
    input  im_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr,
    output im_instr
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock, synchronous active-high reset
//   clear      : insert a bubble (valid=0, instr=NOP), pc/pc4 keep old values
//   capture    : load pc_in/instr_in, pc4 = pc_in + 4, valid=1
//   neither    : hold every field
//   valid, pc, pc4, instr : registered outputs
module ifid_reg
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      pc4   <= 32'h4;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (capture) begin
      valid <= 1'b1;
      pc    <= pc_in;
      pc4   <= pc_in + 32'd4;
      instr <= instr_in;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the word-indexed IM and
// fills the IF/ID register. Handles stall, flush, redirect and misaligned
// redirect traps.
//   clk, reset   : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID
//   flush        : squash IF/ID (bubble)
//   redirect     : taken branch / jal / jalr, target in redirect_pc
//   bus          : IM address/data and IF/ID outputs (master side)
//   trap/trap_pc : sticky misaligned-redirect flag and offending target
//   fetch_count  : instructions captured into IF/ID (wraps)
module if_stage #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
  parameter int          XLEN     = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  if_stage_if.master      bus,
  output logic            trap,
  output logic [31:0]     trap_pc,
  output logic [31:0]     fetch_count
);
  import rv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc;
  logic            capture, clear, trap_set;

  assign pc_inc      = pc_q + 32'd4;  // modulo 2^32
  assign bus.im_addr = pc_q[17:2];    // upper PC bits alias: 256 KiB wrap

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      trap        <= 1'b0;
      trap_pc     <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (trap_set) begin
        trap    <= 1'b1;
        trap_pc <= redirect_pc;
      end
      if (capture) fetch_count <= fetch_count + 32'd1;
    end
  end

  // Redirect outranks stall so a wrong-path fetch is never held in IF/ID.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    capture  = 1'b0;
    clear    = 1'b0;
    trap_set = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          clear = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            state_d  = TRAP;
            trap_set = 1'b1;
          end
        end else if (flush) begin
          clear = 1'b1;
          if (!stall) pc_d = pc_inc;
        end else if (!stall) begin
          capture = 1'b1;
          pc_d    = pc_inc;
        end
      end
      default: ;  // TRAP: frozen until reset; IF/ID was cleared on entry
    endcase
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .capture  (capture),
    .pc_in    (pc_q),
    .instr_in (bus.im_instr),
    .valid    (bus.ifid_valid),
    .pc       (bus.ifid_pc),
    .pc4      (bus.ifid_pc4),
    .instr    (bus.ifid_instr)
  );
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The IM model returns {16'hC0DE, word index},
// so a captured instruction identifies the PC it was fetched from.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] trap_pc, fetch_count;

  if_stage_if bus ();
  assign bus.im_instr = {16'hC0DE, bus.im_addr};

  if_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, fls, rd;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] ipc, ipc4;
    logic [15:0] ima;
    logic [31:0] cnt;
    logic        tr;
    logic [31:0] tpc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, stl, fls, rd, input logic [31:0] rpc,
                     input logic v, input logic [31:0] ipc, ipc4,
                     input logic [15:0] ima, input logic [31:0] cnt,
                     input logic tr, input logic [31:0] tpc);
    vec_t r;
    r.rst = rst; r.stl = stl; r.fls = fls; r.rd = rd; r.rpc = rpc;
    r.v = v; r.ipc = ipc; r.ipc4 = ipc4; r.ima = ima; r.cnt = cnt;
    r.tr = tr; r.tpc = tpc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stl, fls, rd, input logic [31:0] rpc);
    reset = rst; stall = stl; flush = fls; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic check_all(input string tag, input vec_t r);
    logic [31:0] exp_instr;
    exp_instr = r.v ? {16'hC0DE, r.ipc[17:2]} : NOP;
    chk({tag, " valid"},   {31'h0, bus.ifid_valid}, {31'h0, r.v});
    chk({tag, " pc"},      bus.ifid_pc,            r.ipc);
    chk({tag, " pc4"},     bus.ifid_pc4,           r.ipc4);
    chk({tag, " instr"},   bus.ifid_instr,         exp_instr);
    chk({tag, " im_addr"}, {16'h0, bus.im_addr},   {16'h0, r.ima});
    chk({tag, " count"},   fetch_count,            r.cnt);
    chk({tag, " trap"},    {31'h0, trap},          {31'h0, r.tr});
    chk({tag, " trap_pc"}, trap_pc,                r.tpc);
  endtask

  initial begin
    vec_t r;
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //  rst stl fls rd  rpc            v  ipc        ipc4   ima      cnt tr tpc
    add(1, 0, 0, 0, 32'h0,           0, 32'h0,     32'h4,  16'h0,    0, 0, 0);  // reset state
    add(0, 0, 0, 0, 32'h0,           0, 32'h0,     32'h4,  16'h0,    0, 0, 0);  // BOOT, no capture
    add(0, 0, 0, 0, 32'h0,           1, 32'h0,     32'h4,  16'h1,    1, 0, 0);  // first fetch
    add(0, 0, 0, 0, 32'h0,           1, 32'h4,     32'h8,  16'h2,    2, 0, 0);
    for (int i = 0; i < 3; i++)                                               // stall at pc 8
      add(0, 1, 0, 0, 32'h0,         1, 32'h4,     32'h8,  16'h2,    2, 0, 0);
    add(0, 0, 0, 0, 32'h0,           1, 32'h8,     32'hC,  16'h3,    3, 0, 0);
    add(0, 0, 0, 0, 32'h0,           1, 32'hC,     32'h10, 16'h4,    4, 0, 0);
    add(0, 0, 1, 1, 32'h40,          0, 32'hC,     32'h10, 16'h10,   4, 0, 0);  // redirect beats flush
    add(0, 0, 0, 0, 32'h0,           1, 32'h40,    32'h44, 16'h11,   5, 0, 0);
    add(0, 1, 0, 1, 32'h40,          0, 32'h40,    32'h44, 16'h10,   5, 0, 0);  // redirect beats stall
    add(0, 0, 0, 0, 32'h0,           1, 32'h40,    32'h44, 16'h11,   6, 0, 0);
    add(0, 0, 0, 1, 32'h20,          0, 32'h40,    32'h44, 16'h8,    6, 0, 0);
    add(0, 1, 1, 0, 32'h0,           0, 32'h40,    32'h44, 16'h8,    6, 0, 0);  // flush+stall: PC held
    add(0, 0, 1, 0, 32'h0,           0, 32'h40,    32'h44, 16'h9,    6, 0, 0);  // flush: PC advances
    add(0, 0, 0, 0, 32'h0,           1, 32'h24,    32'h28, 16'hA,    7, 0, 0);
    add(0, 1, 0, 1, 32'h42,          0, 32'h24,    32'h28, 16'hA,    7, 1, 32'h42); // misaligned
    for (int i = 0; i < 10; i++)                                              // trap ignores inputs
      add(0, i[0], i[1], i[2] | i[3], 32'h100 + 32'(i * 4),
                                     0, 32'h24,    32'h28, 16'hA,    7, 1, 32'h42);
    add(1, 0, 0, 1, 32'h80,          0, 32'h0,     32'h4,  16'h0,    0, 0, 0);  // reset beats redirect
    add(0, 0, 0, 0, 32'h0,           0, 32'h0,     32'h4,  16'h0,    0, 0, 0);  // BOOT
    add(0, 0, 0, 0, 32'h0,           1, 32'h0,     32'h4,  16'h1,    1, 0, 0);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,   0, 32'h0,     32'h4,  16'hFFFF, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,           1, 32'hFFFF_FFFC, 32'h0, 16'h0, 2, 0, 0);  // PC wraps to 0

    foreach (tbl[i]) begin
      r = tbl[i];
      drive(r.rst, r.stl, r.fls, r.rd, r.rpc);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), r);
    end

    // BOOT ignores a misaligned redirect: no trap, fetch starts at 0.
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 32'h2);
    @(posedge clk); #1;
    chk("boot_rd trap", {31'h0, trap}, 32'h0);
    chk("boot_rd im_addr", {16'h0, bus.im_addr}, 32'h0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("boot_rd valid", {31'h0, bus.ifid_valid}, 32'h1);
    chk("boot_rd pc", bus.ifid_pc, 32'h0);
    chk("boot_rd count", fetch_count, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
